// File: rtl/llr_pingpong_buf.sv
// Double-buffered channel-LLR store: converts sign-magnitude beats to saturated
// two's-complement LLRs, fills one bank while the decoder reads the other.
module llr_pingpong_buf #(
  parameter int W_LLR = 7,
  parameter int LANES = 8,
  parameter int DEPTH = 1024,
  parameter int NRD   = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic [1:0]                 i_mode,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [LANES*(W_LLR+1)-1:0] i_data,
  output logic                       o_frame_rdy,
  output logic [AW:0]                o_len,
  input  logic                       i_release,
  input  logic [NRD*AW-1:0]          i_pos,
  output logic [NRD*W_LLR-1:0]       o_data
);
  localparam int FW = W_LLR + 1;
  localparam logic [AW:0] LANES_W = (AW+1)'(LANES);
  localparam logic [W_LLR-1:0] MAG_MAX = {1'b0, {(W_LLR-1){1'b1}}};

  logic signed [W_LLR-1:0] mem [2*DEPTH];
  logic [1:0]  full;
  logic        wr_bank;
  logic        rd_bank;
  logic [AW:0] wr_base;
  logic [AW:0] len_q [2];
  logic [AW:0] cur_len;
  logic        accept;
  logic        last_beat;
  logic        rel;

  function automatic logic [AW:0] mode_len(input logic [1:0] m);
    case (m)
      2'd0:    return (AW+1)'(DEPTH);
      2'd1:    return (AW+1)'(DEPTH/2);
      default: return (AW+1)'(DEPTH/4);
    endcase
  endfunction

  // Sign-magnitude to two's complement with magnitude saturation; -0 maps to 0.
  function automatic logic signed [W_LLR-1:0] to_llr(input logic [FW-1:0] f);
    logic [W_LLR-1:0] mag;
    mag = f[W_LLR-1:0];
    if (mag > MAG_MAX) mag = MAG_MAX;
    return f[FW-1] ? -$signed(mag) : $signed(mag);
  endfunction

  assign o_ready     = !full[wr_bank];
  assign o_frame_rdy = full[rd_bank];
  assign o_len       = full[rd_bank] ? len_q[rd_bank] : '0;
  assign accept      = i_valid && o_ready;
  assign rel         = i_release && full[rd_bank];
  // Frame length comes from i_mode only on beat 0; later beats use the latched value.
  assign cur_len     = (wr_base == '0) ? mode_len(i_mode) : len_q[wr_bank];
  assign last_beat   = (wr_base + LANES_W) == cur_len;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_base  <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
    end else begin
      if (accept) begin
        if (wr_base == '0) len_q[wr_bank] <= cur_len;
        if (last_beat) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_base       <= '0;
        end else begin
          wr_base <= wr_base + LANES_W;
        end
      end
      // A completing write and a release always target different banks.
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < LANES; k++)
        mem[{wr_bank, wr_base[AW-1:0] + AW'(k)}] <= to_llr(i_data[k*FW +: FW]);
    end
  end

  always_comb begin
    o_data = '0;
    for (int j = 0; j < NRD; j++) begin
      if (full[rd_bank] && ({1'b0, i_pos[j*AW +: AW]} < len_q[rd_bank]))
        o_data[j*W_LLR +: W_LLR] = mem[{rd_bank, i_pos[j*AW +: AW]}];
    end
  end

endmodule

// File: tb/tb_llr_pingpong_buf.sv
// Scoreboard bench for llr_pingpong_buf: stimulus queues expected reads, a
// monitor drives read addresses and compares whenever a frame is presented.
module tb_llr_pingpong_buf;
  localparam int W_LLR = 7;
  localparam int LANES = 8;
  localparam int DEPTH = 1024;
  localparam int NRD   = 6;
  localparam int AW    = 10;
  localparam int FW    = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic                 valid = 1'b0;
  logic                 ready;
  logic [63:0]          data = '0;
  logic                 frame_rdy;
  logic [AW:0]          len;
  logic                 rel = 1'b0;
  logic [NRD*AW-1:0]    pos = '0;
  logic [NRD*W_LLR-1:0] rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cyc0;

  typedef struct {
    string name;
    int    pos;
    int    exp_d;
    int    exp_len;
  } item_t;
  item_t q[$];

  llr_pingpong_buf #(.W_LLR(W_LLR), .LANES(LANES), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_mode(mode),
    .i_valid(valid), .o_ready(ready), .i_data(data),
    .o_frame_rdy(frame_rdy), .o_len(len), .i_release(rel),
    .i_pos(pos), .o_data(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_beat(input int b, input int off);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) d[k*FW +: FW] = 8'((b*LANES + k + off) % 64);
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    valid = 1'b1;
    data  = d;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL beat_accept: o_ready stayed %0d for %0d cycles, expected 1", ready, n);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_frame(input int m, input int nbeats, input int off);
    mode = 2'(m);
    for (int b = 0; b < nbeats; b++) send_beat(mk_beat(b, off));
  endtask

  task automatic expect_rd(input string name, input int p, input int d, input int l);
    item_t it;
    it.name = name; it.pos = p; it.exp_d = d; it.exp_len = l;
    q.push_back(it);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d reads still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic release_pulse();
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
  endtask

  // Monitor: consumes one queued read per cycle while a frame is presented.
  initial begin
    item_t it;
    int got, bad_got, bad_port;
    forever begin
      @(negedge clk);
      if (q.size() != 0 && frame_rdy) begin
        it = q.pop_front();
        for (int j = 0; j < NRD; j++) pos[j*AW +: AW] = AW'(it.pos);
        #1;
        bad_port = -1;
        bad_got  = 0;
        for (int j = 0; j < NRD; j++) begin
          got = int'($signed(rdata[j*W_LLR +: W_LLR]));
          if (got != it.exp_d && bad_port < 0) begin
            bad_port = j;
            bad_got  = got;
          end
        end
        tests++;
        if (bad_port >= 0) begin
          fails++;
          $display("FAIL %s: port %0d pos %0d got %0d, expected %0d",
                   it.name, bad_port, it.pos, bad_got, it.exp_d);
        end
        chk({it.name, "_len"}, int'(len), it.exp_len);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] conv;
    conv = {24'h0, 8'h7F, 8'hFF, 8'h80, 8'h05, 8'h85};

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_frame_rdy", int'(frame_rdy), 0);
    chk("rst_len", int'(len), 0);
    chk("rst_data_ones", $countones(rdata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame A: full length, ramp pattern
    mode = 2'd0;
    for (int b = 0; b < 127; b++) send_beat(mk_beat(b, 0));
    chk("a_not_rdy_early", int'(frame_rdy), 0);
    send_beat(mk_beat(127, 0));
    chk("a_rdy", int'(frame_rdy), 1);
    chk("a_len", int'(len), 1024);
    expect_rd("a_pos5", 5, 5, 1024);
    expect_rd("a_pos1023", 1023, 63, 1024);
    expect_rd("a_pos130", 130, 2, 1024);
    drain();
    release_pulse();
    chk("a_rel_rdy", int'(frame_rdy), 0);
    chk("a_rel_len", int'(len), 0);

    // Frame B: quarter length, conversion beat, mode change mid-frame ignored
    mode = 2'd2;
    for (int b = 0; b < 32; b++) begin
      if (b == 10) mode = 2'd0;
      send_beat(b == 0 ? conv : mk_beat(b, 0));
    end
    chk("b_rdy", int'(frame_rdy), 1);
    expect_rd("b_conv0", 0, -5, 256);
    expect_rd("b_conv1", 1, 5, 256);
    expect_rd("b_conv2", 2, 0, 256);
    expect_rd("b_conv3", 3, -63, 256);
    expect_rd("b_conv4", 4, 63, 256);
    expect_rd("b_pos255", 255, 63, 256);
    expect_rd("b_pos300", 300, 0, 256);
    drain();
    release_pulse();

    // Frames C (half) and D (quarter) back to back, no release
    send_frame(1, 64, 1);
    chk("c_rdy", int'(frame_rdy), 1);
    chk("c_ready", int'(ready), 1);
    cyc0 = cyc;
    send_frame(2, 32, 7);
    chk("d_cycles", cyc - cyc0, 32);
    chk("both_full_ready", int'(ready), 0);
    valid = 1'b1;
    data  = mk_beat(0, 50);
    mode  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", int'(ready), 0);
    end
    valid = 1'b0;
    chk("c_len_after_stall", int'(len), 512);
    expect_rd("c_pos0", 0, 1, 512);
    expect_rd("c_pos511", 511, 0, 512);
    expect_rd("c_pos100", 100, 37, 512);
    expect_rd("c_pos600", 600, 0, 512);
    drain();
    release_pulse();
    chk("d_ready", int'(ready), 1);
    chk("d_rdy", int'(frame_rdy), 1);
    chk("d_len", int'(len), 256);
    expect_rd("d_pos0", 0, 7, 256);
    expect_rd("d_pos255", 255, 6, 256);
    expect_rd("d_pos256", 256, 0, 256);
    drain();

    // Frame E: last beat coincides with release of D
    mode = 2'd2;
    for (int b = 0; b < 31; b++) send_beat(mk_beat(b, 20));
    chk("e_ready_pre", int'(ready), 1);
    valid = 1'b1;
    data  = mk_beat(31, 20);
    rel   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    rel   = 1'b0;
    chk("e_rdy", int'(frame_rdy), 1);
    chk("e_ready", int'(ready), 1);
    chk("e_len", int'(len), 256);
    expect_rd("e_pos0", 0, 20, 256);
    expect_rd("e_pos200", 200, 28, 256);
    expect_rd("e_pos255", 255, 19, 256);
    drain();
    release_pulse();
    chk("e_rel_rdy", int'(frame_rdy), 0);

    // Frame F full, partial G, then clear
    send_frame(0, 128, 9);
    chk("f_rdy", int'(frame_rdy), 1);
    send_frame(0, 50, 40);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_rdy", int'(frame_rdy), 0);
    chk("clr_ready", int'(ready), 1);
    chk("clr_len", int'(len), 0);

    // Frame H after clear lands in bank 0
    send_frame(0, 128, 33);
    chk("h_rdy", int'(frame_rdy), 1);
    expect_rd("h_pos0", 0, 33, 1024);
    expect_rd("h_pos1023", 1023, 32, 1024);
    expect_rd("h_pos777", 777, 42, 1024);
    expect_rd("h_pos395", 395, 44, 1024);
    drain();
    release_pulse();
    chk("h_rel_rdy", int'(frame_rdy), 0);

    // Release with nothing presented must not move the read bank
    release_pulse();
    chk("ign_rdy", int'(frame_rdy), 0);
    chk("ign_ready", int'(ready), 1);
    send_frame(2, 32, 0);
    chk("fin_rdy", int'(frame_rdy), 1);
    expect_rd("fin_pos3", 3, 3, 256);
    expect_rd("fin_pos500", 500, 0, 256);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/llr_pingpong_buf.md
# llr_pingpong_buf

Parametrised, double-buffered channel-LLR store for the decoder front end. Converts packed sign-magnitude input beats into saturated two's-complement LLRs, fills one bank while the decoder reads the other through NRD combinational random-access ports, and exchanges frames via a valid/ready write handshake and a frame-ready/release read handshake. Frame length is selectable per frame (DEPTH, DEPTH/2, DEPTH/4).

## Interface
- W_LLR, 7: output LLR width (two's complement); input field width is W_LLR+1
- LANES, 8: LLRs per input beat
- DEPTH, 1024: entries per bank; power of two, DEPTH/4 a multiple of LANES
- NRD, 6: number of read ports
- AW, $clog2(DEPTH): read address width (derived)

- i_clk  in  1  clock; reset i_rst_n, synchronous, active-low; clock i_clk
- i_rst_n  in  1  synchronous active-low reset
- i_clear  in  1  synchronous soft flush (same effect as reset on control state)
- i_mode  in  2  frame length select: 0→DEPTH, 1→DEPTH/2, 2→DEPTH/4, 3→treated as 2
- i_valid  in  1  input beat valid
- o_ready  out  1  fill bank can accept a beat
- i_data  in  LANES*(W_LLR+1)  lane k at bits [k*(W_LLR+1) +: W_LLR+1], MSB = sign, rest = magnitude
- o_frame_rdy  out  1  read bank holds a complete frame
- o_len  out  AW+1  frame length of the read bank (0 when !o_frame_rdy)
- i_release  in  1  decoder finished with read bank
- i_pos  in  NRD*AW  read addresses, port j at [j*AW +: AW]
- o_data  out  NRD*W_LLR  read data, port j at [j*W_LLR +: W_LLR]

## Operation
- Conversion per lane: mag saturated to 2^(W_LLR-1)-1 (63 at default); value = sign ? -mag_sat : mag_sat. Sign=1 with mag=0 stores 0.
- Addressing: lane k of beat b in frame stored at index b*LANES+k (no shifting).
- State: two banks, full[1:0], wr_bank, rd_bank, beat counter wr_cnt, per-bank latched length len[1:0].
- Frame length N latched from i_mode at acceptance of beat 0 of a frame; i_mode changes mid-frame ignored. Beats per frame = N/LANES.
- o_ready = !full[wr_bank].
- Beat accepted when i_valid && o_ready: write LANES entries, wr_cnt++. On last beat: full[wr_bank]←1, wr_bank toggles, wr_cnt←0.
- o_frame_rdy = full[rd_bank]; o_len = len[rd_bank] when ready.
- i_release with o_frame_rdy: full[rd_bank]←0, rd_bank toggles. i_release without o_frame_rdy: ignored.
- Read: o_data[j] = bank[rd_bank][i_pos[j]] if o_frame_rdy and i_pos[j] < len[rd_bank], else 0.
- Entries beyond N in a bank are don't-care storage; never visible on o_data.
- Bank contents are not reset; only control state is.

## Timing
- Reset/clear values: o_ready=1, o_frame_rdy=0, o_len=0, o_data=0, wr_bank=rd_bank=0, wr_cnt=0, full=0.
- Write latency: entry visible on reads the cycle after the accepting edge of the frame's last beat (o_frame_rdy rises that cycle).
- Read latency: zero (combinational from i_pos and registered state).
- Release: o_frame_rdy falls next cycle unless other bank already full, in which case it stays 1 and o_data/o_len switch to the other bank next cycle.
- Both banks full: o_ready=0; rises the cycle after an accepted release.
- Same-cycle last-beat completion and release: both take effect; never lose a frame.
- i_valid while o_ready=0: beat not accepted; source holds data.
- i_clear/reset mid-frame: partial frame discarded, full frames dropped, next beat starts new frame in bank 0.
- Back-to-back frames: no bubble; beat 0 of next frame accepted the cycle after the last beat if the other bank is empty.

## Test plan
- Default params, i_mode=0, 128 beats with lane k of beat b = {0, (b*8+k)%64}, no stalls → o_frame_rdy=1 after beat 127, o_len=1024, i_pos=5 → 5, i_pos=1023 → 63.
- Conversion: lanes 0x85, 0x05, 0x80, 0xFF, 0x7F → stored -5, 5, 0, -63, 63.
- i_mode=2 frame (32 beats) → o_len=256; i_pos=300 → 0; changing i_mode to 0 at beat 10 does not alter o_len.
- Fill two frames without release → o_ready=0 after 2nd frame; i_valid held high stalls; i_release → next cycle o_ready=1, o_data from bank 1.
- Last beat of frame 2 and i_release same cycle → next cycle o_frame_rdy=1 showing frame 2, o_ready=1.
- i_clear at beat 50 of a frame → o_frame_rdy=0, o_ready=1, next 128 beats produce a complete frame with correct index mapping.
